// File: rtl/bimodal_pht.sv
// Bimodal pattern history table: one 2-bit saturating counter per PC-indexed entry,
// registered lookup with same-cycle update bypass, and saturating perf counters.
module bimodal_pht #(
  parameter int          PC_W       = 32,
  parameter int          INDEX_W    = 8,
  parameter logic [1:0]  INIT_STATE = 2'b01,
  parameter int          CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_lookup_en,
  input  logic [PC_W-1:0]  i_lookup_pc,
  input  logic             i_flush,
  output logic             o_pred_valid,
  output logic             o_pred_taken,
  output logic [1:0]       o_pred_state,
  input  logic             i_upd_en,
  input  logic [PC_W-1:0]  i_upd_pc,
  input  logic             i_upd_taken,
  input  logic             i_upd_pred,
  output logic [CNT_W-1:0] o_upd_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam int DEPTH = 1 << INDEX_W;

  ctr_t pht [DEPTH];

  logic [INDEX_W-1:0] lidx;
  logic [INDEX_W-1:0] uidx;
  ctr_t               upd_next;
  ctr_t               rd_state;
  logic               unused_pc_bits;

  assign lidx = i_lookup_pc[INDEX_W+1:2];
  assign uidx = i_upd_pc[INDEX_W+1:2];
  assign unused_pc_bits = ^{i_lookup_pc[PC_W-1:INDEX_W+2], i_lookup_pc[1:0],
                            i_upd_pc[PC_W-1:INDEX_W+2], i_upd_pc[1:0]};

  function automatic ctr_t next_state(input ctr_t s, input logic taken);
    ctr_t n;
    n = s;
    unique case (s)
      SNT: n = taken ? WNT : SNT;
      WNT: n = taken ? WT  : SNT;
      WT:  n = taken ? ST  : WNT;
      ST:  n = taken ? ST  : WT;
      default: n = s;
    endcase
    return n;
  endfunction

  always_comb begin
    upd_next = next_state(pht[uidx], i_upd_taken);
    rd_state = pht[lidx];
    // Forward the in-flight update so a same-cycle lookup never sees the stale entry
    if (i_upd_en && (uidx == lidx)) begin
      rd_state = upd_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pht[i] <= ctr_t'(INIT_STATE);
      end
    end else if (i_upd_en) begin
      pht[uidx] <= upd_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pred_valid <= 1'b0;
      o_pred_state <= '0;
    end else begin
      o_pred_valid <= i_lookup_en && !i_flush;
      if (i_lookup_en && !i_flush) begin
        o_pred_state <= rd_state;
      end
    end
  end

  assign o_pred_taken = o_pred_state[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_upd_cnt     <= '0;
      o_mispred_cnt <= '0;
    end else if (i_upd_en) begin
      if (o_upd_cnt != '1) begin
        o_upd_cnt <= o_upd_cnt + CNT_W'(1);
      end
      if ((i_upd_pred != i_upd_taken) && (o_mispred_cnt != '1)) begin
        o_mispred_cnt <= o_mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bimodal_pht.sv
// Scoreboard bench for bimodal_pht: expected predictions are queued when a lookup
// is driven and checked by a monitor one cycle later.
`timescale 1ns/100ps
module tb_bimodal_pht;

  logic        clk;
  logic        rst;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        flush;
  logic        pred_valid;
  logic        pred_taken;
  logic [1:0]  pred_state;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_pred;
  logic [15:0] upd_cnt;
  logic [15:0] mispred_cnt;

  typedef struct {
    logic [1:0] state;
    logic       taken;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  bimodal_pht #(
    .PC_W(32),
    .INDEX_W(8),
    .INIT_STATE(2'b01),
    .CNT_W(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_lookup_en(lookup_en),
    .i_lookup_pc(lookup_pc),
    .i_flush(flush),
    .o_pred_valid(pred_valid),
    .o_pred_taken(pred_taken),
    .o_pred_state(pred_state),
    .i_upd_en(upd_en),
    .i_upd_pc(upd_pc),
    .i_upd_taken(upd_taken),
    .i_upd_pred(upd_pred),
    .o_upd_cnt(upd_cnt),
    .o_mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus at a falling edge and return at the next falling edge
  task automatic step(input logic le, input logic [31:0] lpc, input logic fl,
                      input logic ue, input logic [31:0] upc, input logic ut,
                      input logic up);
    lookup_en = le;
    lookup_pc = lpc;
    flush     = fl;
    upd_en    = ue;
    upd_pc    = upc;
    upd_taken = ut;
    upd_pred  = up;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [1:0] exp_state);
    exp_q.push_back('{state: exp_state, taken: exp_state[1]});
    step(1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic pred);
    step(1'b0, 32'h0, 1'b0, 1'b1, pc, taken, pred);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (pred_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pred_unexpected: valid=1 state=%b, required no prediction", pred_state);
        end else begin
          e = exp_q.pop_front();
          if (pred_state !== e.state || pred_taken !== e.taken) begin
            errors++;
            $display("FAIL pred_value: state=%b taken=%b, required state=%b taken=%b",
                     pred_state, pred_taken, e.state, e.taken);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    idle();
    checks++;
    if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || pred_state !== 2'b00 ||
        upd_cnt !== 16'h0 || mispred_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b taken=%b state=%b upd=%h mis=%h, required 0 0 00 0000 0000",
               pred_valid, pred_taken, pred_state, upd_cnt, mispred_cnt);
    end
    rst = 1'b0;
    idle();
    lookup(32'h0000_0040, 2'b01);
    idle();
  endtask

  task automatic test_saturate();
    repeat (3) update(32'h40, 1'b1, 1'b0);
    lookup(32'h40, 2'b11);
    checks++;
    if (upd_cnt !== 16'd3 || mispred_cnt !== 16'd3) begin
      errors++;
      $display("FAIL sat_counts: upd=%0d mis=%0d, required 3 3", upd_cnt, mispred_cnt);
    end
    idle();
    checks++;
    if (pred_state !== 2'b11 || pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_state: valid=%b state=%b, required 0 11", pred_valid, pred_state);
    end
    update(32'h40, 1'b0, 1'b1);
    lookup(32'h40, 2'b10);
    checks++;
    if (upd_cnt !== 16'd4 || mispred_cnt !== 16'd4) begin
      errors++;
      $display("FAIL sat_counts2: upd=%0d mis=%0d, required 4 4", upd_cnt, mispred_cnt);
    end
    idle();
  endtask

  task automatic test_bypass();
    exp_q.push_back('{state: 2'b10, taken: 1'b1});
    step(1'b1, 32'h80, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0);
    lookup(32'h80, 2'b10);
    // different index: no forwarding
    exp_q.push_back('{state: 2'b01, taken: 1'b0});
    step(1'b1, 32'hC0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
    lookup(32'h100, 2'b10);
    lookup(32'hC0, 2'b01);
    checks++;
    if (upd_cnt !== 16'd6 || mispred_cnt !== 16'd6) begin
      errors++;
      $display("FAIL bypass_counts: upd=%0d mis=%0d, required 6 6", upd_cnt, mispred_cnt);
    end
    idle();
  endtask

  task automatic test_alias();
    update(32'h440, 1'b1, 1'b1);
    lookup(32'h40, 2'b11);
    lookup(32'h440, 2'b11);
    checks++;
    if (upd_cnt !== 16'd7 || mispred_cnt !== 16'd6) begin
      errors++;
      $display("FAIL alias_counts: upd=%0d mis=%0d, required 7 6", upd_cnt, mispred_cnt);
    end
    idle();
  endtask

  task automatic test_flush_and_reset();
    step(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: valid=%b, required 0", pred_valid);
    end
    lookup(32'h40, 2'b11);
    update(32'h80, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || pred_state !== 2'b00 ||
        upd_cnt !== 16'h0 || mispred_cnt !== 16'h0) begin
      errors++;
      $display("FAIL midcycle_reset: valid=%b taken=%b state=%b upd=%h mis=%h, required 0 0 00 0000 0000",
               pred_valid, pred_taken, pred_state, upd_cnt, mispred_cnt);
    end
    rst = 1'b0;
    idle();
    lookup(32'h40, 2'b01);
    lookup(32'h80, 2'b01);
    lookup(32'h100, 2'b01);
    // an update coinciding with a reset edge is discarded
    rst = 1'b1;
    update(32'h40, 1'b1, 1'b0);
    rst = 1'b0;
    lookup(32'h40, 2'b01);
    checks++;
    if (upd_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_edge_update: upd=%0d, required 0", upd_cnt);
    end
    idle();
  endtask

  task automatic test_counter_saturation();
    repeat (65535) update(32'h40, 1'b1, 1'b0);
    checks++;
    if (mispred_cnt !== 16'hFFFF || upd_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_reach_max: upd=%h mis=%h, required ffff ffff", upd_cnt, mispred_cnt);
    end
    update(32'h40, 1'b0, 1'b1);
    checks++;
    if (mispred_cnt !== 16'hFFFF || upd_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_no_wrap: upd=%h mis=%h, required ffff ffff", upd_cnt, mispred_cnt);
    end
    lookup(32'h40, 2'b10);
    idle();
  endtask

  initial begin
    rst       = 1'b1;
    lookup_en = 1'b0;
    lookup_pc = '0;
    flush     = 1'b0;
    upd_en    = 1'b0;
    upd_pc    = '0;
    upd_taken = 1'b0;
    upd_pred  = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_saturate();
    test_bypass();
    test_alias();
    test_flush_and_reset();
    test_counter_saturation();
    idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pred_missing: %0d predictions outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
